// File: rtl/execute_stage_pkg.sv
// execute_stage_pkg
// Shared pipeline definitions for the RV32I execute stage:
//   - XLEN datapath width
//   - ALU opcode enum and forward-select enum
//   - branch funct3 constants
//   - packed ID/EX and EX/MEM pipeline register structs
//   - fwd_mux helper for the hazard-unit forwarding muxes
package execute_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLT   = 4'd5,
        ALU_SLTU  = 4'd6,
        ALU_SLL   = 4'd7,
        ALU_SRL   = 4'd8,
        ALU_SRA   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_MUL   = 4'd11
    } alu_op_e;

    // Select 2'b11 is not named: it falls back to the register value.
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_W   = 2'b01,
        FWD_M   = 2'b10
    } fwd_sel_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      alu_ctrl;
        logic [2:0]      funct3;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic [1:0]      result_src;
    } id_ex_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_write;
        logic [1:0]      result_src;
    } ex_mem_t;

    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] w_val,
        input logic [XLEN-1:0] m_val
    );
        case (fwd_sel_e'(sel))
            FWD_W:   return w_val;
            FWD_M:   return m_val;
            default: return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu
// Purely combinational RV32I ALU.
//   src_a, src_b : operands (shift amount is src_b[4:0])
//   alu_ctrl     : alu_op_e opcode; undefined codes produce 0
//   result       : XLEN-bit result, arithmetic modulo 2^XLEN
// Configuration: with EXEC_MUL_EN defined, opcode 11 returns the low XLEN
// bits of src_a * src_b; otherwise it returns 0 like any other unused code.
module exec_alu
    import execute_stage_pkg::*;
(
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic [3:0]      alu_ctrl,
    output logic [XLEN-1:0] result
);

    logic [4:0] shamt;
    assign shamt = src_b[4:0];

    // NOTE: result gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        result = '0;
        case (alu_op_e'(alu_ctrl))
            ALU_ADD:   result = src_a + src_b;
            ALU_SUB:   result = src_a - src_b;
            ALU_AND:   result = src_a & src_b;
            ALU_OR:    result = src_a | src_b;
            ALU_XOR:   result = src_a ^ src_b;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_SLL:   result = src_a << shamt;
            ALU_SRL:   result = src_a >> shamt;
            ALU_SRA:   result = $unsigned($signed(src_a) >>> shamt);
            ALU_PASSB: result = src_b;
`ifdef EXEC_MUL_EN
            ALU_MUL:   result = src_a * src_b;
`endif
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// execute_stage
// Execute stage of the five-stage RV32I pipeline: ID/EX register, operand
// forwarding muxes, ALU, branch/jump resolution and EX/MEM register.
// Ports:
//   CLK, RST_N            clock (rising edge), asynchronous active-low reset
//   StallE, FlushE        hold / bubble the ID/EX register (flush wins)
//   *D inputs             decode-stage data and controls captured into ID/EX
//   ForwardAE/BE, ResultW forwarding selects and writeback-stage result
//   RS1E, RS2E, RdE       ID/EX register indices for the hazard unit
//   PCSrcE, PCTargetE     redirect request and target, combinational from E
//   *M outputs            EX/MEM register contents
//   BusyE                 multiply in progress
// Configuration: EXEC_MUL_EN enables the two-cycle multiplier (opcode 11)
// and its IDLE/MUL FSM; without it BusyE is tied 0.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdD,
    input  logic [3:0]      ALUControlD,
    input  logic [2:0]      Funct3D,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic            JalrD,
    input  logic [1:0]      ResultSrcD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic [4:0]      RS1E,
    output logic [4:0]      RS2E,
    output logic [4:0]      RdE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic            BusyE
);

    id_ex_t          id_ex_q, id_ex_d, id_ex_in;
    ex_mem_t         ex_mem_q, ex_mem_d, ex_mem_e;
    logic [XLEN-1:0] src_a_e, write_data_e, src_b_e, jalr_sum_e;
    logic [XLEN-1:0] alu_a, alu_b, alu_result_e;
    logic [3:0]      alu_ctrl;
    logic            branch_cond_e;
    logic            busy_e;

    // ---------------------------------------------------------------
    // ID/EX
    // ---------------------------------------------------------------
    always_comb begin
        id_ex_in = '{rd1: RD1D, rd2: RD2D, imm: ImmExtD, pc: PCD,
                     pc_plus4: PCPlus4D, rs1: Rs1D, rs2: Rs2D, rd: RdD,
                     alu_ctrl: ALUControlD, funct3: Funct3D,
                     alu_src: ALUSrcD, reg_write: RegWriteD,
                     mem_write: MemWriteD, branch: BranchD, jump: JumpD,
                     jalr: JalrD, result_src: ResultSrcD};
    end

    // A multiply in flight freezes ID/EX regardless of flush or stall; a
    // bubble clears every field so indices and controls both read 0.
    always_comb begin
        id_ex_d = id_ex_q;
        if (busy_e) begin
            id_ex_d = id_ex_q;
        end else if (FlushE) begin
            id_ex_d = '0;
        end else if (!StallE) begin
            id_ex_d = id_ex_in;
        end
    end

    // ---------------------------------------------------------------
    // Forwarding, ALU, branch resolution
    // ---------------------------------------------------------------
    assign src_a_e      = fwd_mux(ForwardAE, id_ex_q.rd1, ResultW, ex_mem_q.alu_result);
    assign write_data_e = fwd_mux(ForwardBE, id_ex_q.rd2, ResultW, ex_mem_q.alu_result);
    assign src_b_e      = id_ex_q.alu_src ? id_ex_q.imm : write_data_e;

    exec_alu u_alu (
        .src_a    (alu_a),
        .src_b    (alu_b),
        .alu_ctrl (alu_ctrl),
        .result   (alu_result_e)
    );

    always_comb begin
        branch_cond_e = 1'b0;
        case (id_ex_q.funct3)
            F3_BEQ:  branch_cond_e = (src_a_e == src_b_e);
            F3_BNE:  branch_cond_e = (src_a_e != src_b_e);
            F3_BLT:  branch_cond_e = ($signed(src_a_e) <  $signed(src_b_e));
            F3_BGE:  branch_cond_e = ($signed(src_a_e) >= $signed(src_b_e));
            F3_BLTU: branch_cond_e = (src_a_e <  src_b_e);
            F3_BGEU: branch_cond_e = (src_a_e >= src_b_e);
            default: branch_cond_e = 1'b0;
        endcase
    end

    assign jalr_sum_e = src_a_e + id_ex_q.imm;
    assign PCSrcE     = id_ex_q.jump | (id_ex_q.branch & branch_cond_e);
    assign PCTargetE  = id_ex_q.jalr ? {jalr_sum_e[XLEN-1:1], 1'b0}
                                     : (id_ex_q.pc + id_ex_q.imm);

    // x0 is filtered here so the hazard unit never forwards from it.
    always_comb begin
        ex_mem_e = '{alu_result: alu_result_e, write_data: write_data_e,
                     pc_plus4: id_ex_q.pc_plus4, rd: id_ex_q.rd,
                     reg_write: id_ex_q.reg_write & (id_ex_q.rd != 5'd0),
                     mem_write: id_ex_q.mem_write,
                     result_src: id_ex_q.result_src};
    end

`ifdef EXEC_MUL_EN
    // ---------------------------------------------------------------
    // Two-cycle multiply. On the IDLE->MUL edge the forwarded operands
    // and the MUL's EX/MEM fields are captured, ID/EX moves on and EX/MEM
    // takes a bubble. During MUL the shared ALU multiplies the captured
    // operands; the product lands in EX/MEM on the MUL->IDLE edge.
    // ---------------------------------------------------------------
    typedef enum logic {S_IDLE, S_MUL} mul_state_e;

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    ex_mem_t         mul_hold_q, mul_hold_d;
    logic            mul_start;

    assign mul_start = (state_q == S_IDLE) && (id_ex_q.alu_ctrl == ALU_MUL);
    assign busy_e    = (state_q == S_MUL);

    always_comb begin
        state_d    = state_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_hold_d = mul_hold_q;
        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    state_d    = S_MUL;
                    mul_a_d    = src_a_e;
                    mul_b_d    = src_b_e;
                    mul_hold_d = ex_mem_e;
                end
            end
            S_MUL:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= S_IDLE;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_hold_q <= mul_hold_d;
        end
    end

    assign alu_a    = busy_e ? mul_a_q : src_a_e;
    assign alu_b    = busy_e ? mul_b_q : src_b_e;
    assign alu_ctrl = busy_e ? ALU_MUL : id_ex_q.alu_ctrl;

    always_comb begin
        ex_mem_d = ex_mem_e;
        if (busy_e) begin
            ex_mem_d            = mul_hold_q;
            ex_mem_d.alu_result = alu_result_e;
        end else if (mul_start) begin
            ex_mem_d = '0;
        end
    end
`else
    assign busy_e   = 1'b0;
    assign alu_a    = src_a_e;
    assign alu_b    = src_b_e;
    assign alu_ctrl = id_ex_q.alu_ctrl;

    always_comb begin
        ex_mem_d = ex_mem_e;
    end
`endif

    // ---------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
        end
    end

    assign RS1E       = id_ex_q.rs1;
    assign RS2E       = id_ex_q.rs2;
    assign RdE        = id_ex_q.rd;
    assign ALUResultM = ex_mem_q.alu_result;
    assign WriteDataM = ex_mem_q.write_data;
    assign PCPlus4M   = ex_mem_q.pc_plus4;
    assign RdM        = ex_mem_q.rd;
    assign RegWriteM  = ex_mem_q.reg_write;
    assign MemWriteM  = ex_mem_q.mem_write;
    assign ResultSrcM = ex_mem_q.result_src;
    assign BusyE      = busy_e;

endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage
// Self-checking bench for execute_stage: randomized instruction stream
// compared against a behavioural model of the E and M stages, plus
// directed forwarding, x0, branch, flush/stall and multiply scenarios.
module tb_execute_stage;

    logic        CLK, RST_N, StallE, FlushE;
    logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D, ResultW;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic [3:0]  ALUControlD;
    logic [2:0]  Funct3D;
    logic        ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, JalrD;
    logic [1:0]  ResultSrcD, ForwardAE, ForwardBE;
    logic [4:0]  RS1E, RS2E, RdE, RdM;
    logic        PCSrcE, RegWriteM, MemWriteM, BusyE;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;

    int checks   = 0;
    int failures = 0;

    execute_stage dut (
        .CLK(CLK), .RST_N(RST_N), .StallE(StallE), .FlushE(FlushE),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .ALUControlD(ALUControlD), .Funct3D(Funct3D), .ALUSrcD(ALUSrcD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .JumpD(JumpD), .JalrD(JalrD), .ResultSrcD(ResultSrcD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .RS1E(RS1E), .RS2E(RS2E), .RdE(RdE), .PCSrcE(PCSrcE),
        .PCTargetE(PCTargetE), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .BusyE(BusyE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    // E stage contents
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [3:0]  e_op;
    logic [2:0]  e_f3;
    logic        e_alusrc, e_rw, e_mw, e_br, e_jp, e_jr;
    logic [1:0]  e_rs;
    // M stage contents
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;

    task automatic clear_e();
        e_rd1 = 0; e_rd2 = 0; e_imm = 0; e_pc = 0; e_pc4 = 0;
        e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_op = 0; e_f3 = 0;
        e_alusrc = 0; e_rw = 0; e_mw = 0; e_br = 0; e_jp = 0; e_jr = 0; e_rs = 0;
    endtask

    task automatic reset_model();
        clear_e();
        m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_rw = 0; m_mw = 0; m_rs = 0;
    endtask

    // Signed order obtained by flipping the sign bit and comparing unsigned.
    function automatic logic s_lt(input logic [31:0] a, input logic [31:0] b);
        return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a + ~b + 32'd1;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return s_lt(a, b) ? 32'd1 : 32'd0;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return a << sh;
            4'd8:  return a >> sh;
            4'd9:  return (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
            4'd10: return b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return s_lt(a, b);
            3'b101:  return !s_lt(a, b);
            3'b110:  return a < b;
            3'b111:  return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] regv);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return m_alu;
        return regv;
    endfunction

    task automatic expect_outputs();
        logic [31:0] a, wd, b, tgt;
        logic        taken;
        a     = ref_fwd(ForwardAE, e_rd1);
        wd    = ref_fwd(ForwardBE, e_rd2);
        b     = e_alusrc ? e_imm : wd;
        taken = e_jp | (e_br & ref_taken(e_f3, a, b));
        tgt   = e_jr ? ((a + e_imm) & 32'hFFFF_FFFE) : (e_pc + e_imm);
        check("rs1e",    32'(RS1E),       32'(e_rs1));
        check("rs2e",    32'(RS2E),       32'(e_rs2));
        check("rde",     32'(RdE),        32'(e_rd));
        check("pcsrce",  32'(PCSrcE),     32'(taken));
        check("pctarg",  PCTargetE,       tgt);
        check("alu_m",   ALUResultM,      m_alu);
        check("wdata_m", WriteDataM,      m_wd);
        check("pc4_m",   PCPlus4M,        m_pc4);
        check("rd_m",    32'(RdM),        32'(m_rd));
        check("rw_m",    32'(RegWriteM),  32'(m_rw));
        check("mw_m",    32'(MemWriteM),  32'(m_mw));
        check("rs_m",    32'(ResultSrcM), 32'(m_rs));
        check("busy",    32'(BusyE),      32'd0);
    endtask

    // Check the current cycle, clock once and advance the model.
    task automatic cycle();
        logic [31:0] a, wd, b;
        #3;
        expect_outputs();
        a  = ref_fwd(ForwardAE, e_rd1);
        wd = ref_fwd(ForwardBE, e_rd2);
        b  = e_alusrc ? e_imm : wd;
        @(posedge CLK);
        m_alu = ref_alu(e_op, a, b);
        m_wd  = wd;
        m_pc4 = e_pc4;
        m_rd  = e_rd;
        m_rw  = e_rw && (e_rd != 5'd0);
        m_mw  = e_mw;
        m_rs  = e_rs;
        if (FlushE) begin
            clear_e();
        end else if (!StallE) begin
            e_rd1 = RD1D; e_rd2 = RD2D; e_imm = ImmExtD; e_pc = PCD; e_pc4 = PCPlus4D;
            e_rs1 = Rs1D; e_rs2 = Rs2D; e_rd = RdD; e_op = ALUControlD; e_f3 = Funct3D;
            e_alusrc = ALUSrcD; e_rw = RegWriteD; e_mw = MemWriteD; e_br = BranchD;
            e_jp = JumpD; e_jr = JalrD; e_rs = ResultSrcD;
        end
        #1;
    endtask

    task automatic edge1();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_nop();
        StallE = 0; FlushE = 0; RD1D = 0; RD2D = 0; ImmExtD = 0; PCD = 0; PCPlus4D = 0;
        Rs1D = 0; Rs2D = 0; RdD = 0; ALUControlD = 0; Funct3D = 0; ALUSrcD = 0;
        RegWriteD = 0; MemWriteD = 0; BranchD = 0; JumpD = 0; JalrD = 0;
        ResultSrcD = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    task automatic rand_inputs();
        RD1D        = $urandom;
        RD2D        = ($urandom_range(0, 3) == 0) ? RD1D : $urandom;
        ImmExtD     = $urandom;
        PCD         = $urandom & 32'hFFFF_FFFC;
        PCPlus4D    = PCD + 32'd4;
        Rs1D        = 5'($urandom);
        Rs2D        = 5'($urandom);
        RdD         = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        ALUControlD = 4'($urandom_range(0, 15));
`ifdef EXEC_MUL_EN
        if (ALUControlD == 4'd11) ALUControlD = 4'd0;
`endif
        Funct3D     = 3'($urandom);
        ALUSrcD     = 1'($urandom);
        RegWriteD   = 1'($urandom);
        MemWriteD   = 1'($urandom);
        BranchD     = 1'($urandom);
        JumpD       = ($urandom_range(0, 3) == 0);
        JalrD       = 1'($urandom);
        ResultSrcD  = 2'($urandom);
        ForwardAE   = 2'($urandom);
        ForwardBE   = 2'($urandom);
        ResultW     = $urandom;
        StallE      = ($urandom_range(0, 4) == 0);
        FlushE      = ($urandom_range(0, 6) == 0);
    endtask

    initial begin
        // ---------------- reset ----------------
        RST_N = 1'b0;
        rand_inputs();
        ForwardAE = 0;
        reset_model();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_pctarg", PCTargetE, 32'h0);
        check("rst_alu_m",  ALUResultM, 32'h0);
        set_nop();
        expect_outputs();
        RST_N = 1'b1;

        // ---------------- randomized stream ----------------
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                RST_N = 1'b0;
                #1;
                check("midrst_rde",   32'(RdE), 32'h0);
                check("midrst_alu_m", ALUResultM, 32'h0);
                check("midrst_rw_m",  32'(RegWriteM), 32'h0);
                reset_model();
                edge1();
                RST_N = 1'b1;
            end
            rand_inputs();
            cycle();
        end

        // ---------------- forward from M ----------------
        set_nop(); RD1D = 5; RD2D = 7; RdD = 3; RegWriteD = 1;
        cycle();
        set_nop(); Rs1D = 3; RD2D = 1; RdD = 4; RegWriteD = 1; JumpD = 1; JalrD = 1;
        cycle();
        check("fwdm_first_res", ALUResultM, 32'd12);
        set_nop(); ForwardAE = 2'b10;
        #3;
        check("fwdm_rs1e", 32'(RS1E), 32'd3);
        check("fwdm_srca", PCTargetE, 32'd12);
        cycle();
        check("fwdm_dep_res", ALUResultM, 32'd13);

        // ---------------- writeback priority + stall hold ----------------
        set_nop(); RD1D = 32'h1; ALUSrcD = 1; RdD = 6; RegWriteD = 1;
        cycle();
        set_nop(); StallE = 1; ForwardAE = 2'b01; ResultW = 32'hDEAD;
        cycle();
        check("fwdw_res",   ALUResultM, 32'hDEAD);
        check("stall_hold", 32'(RdE), 32'd6);
        check("rw_nonzero", 32'(RegWriteM), 32'd1);
        set_nop(); StallE = 1; ForwardAE = 2'b11; ResultW = 32'hDEAD;
        cycle();
        check("fwd11_res", ALUResultM, 32'h1);

        // ---------------- x0 suppression ----------------
        set_nop(); RegWriteD = 1; RdD = 0; RD1D = 9;
        cycle();
        set_nop();
        cycle();
        check("x0_rw_m", 32'(RegWriteM), 32'd0);

        // ---------------- branch ----------------
        set_nop(); BranchD = 1; Funct3D = 3'b100; RD1D = 32'hFFFF_FFFF; RD2D = 0;
        PCD = 32'h100; ImmExtD = 32'h20;
        cycle();
        BranchD = 1; Funct3D = 3'b110;
        #1;
        check("blt_taken",  32'(PCSrcE), 32'd1);
        check("blt_target", PCTargetE, 32'h120);
        cycle();
        set_nop();
        #1;
        check("bltu_taken", 32'(PCSrcE), 32'd0);
        cycle();

        // ---------------- flush + stall ----------------
        set_nop(); RdD = 7; Rs1D = 2; JumpD = 1;
        cycle();
        check("pre_flush_rde", 32'(RdE), 32'd7);
        set_nop(); FlushE = 1; StallE = 1;
        cycle();
        check("flush_rde",   32'(RdE), 32'd0);
        check("flush_rs1e",  32'(RS1E), 32'd0);
        check("flush_pcsrc", 32'(PCSrcE), 32'd0);

        // ---------------- multiply ----------------
`ifdef EXEC_MUL_EN
        set_nop(); RD1D = 32'hFFFF_FFFF; RD2D = 3; ALUControlD = 4'd11; RdD = 5; RegWriteD = 1;
        edge1();
        set_nop();
        check("mul_busy_pre", 32'(BusyE), 32'd0);
        edge1();
        check("mul_busy",      32'(BusyE), 32'd1);
        check("mul_bubble_rw", 32'(RegWriteM), 32'd0);
        edge1();
        check("mul_busy_done", 32'(BusyE), 32'd0);
        check("mul_res",       ALUResultM, 32'hFFFF_FFFD);
        check("mul_rd_m",      32'(RdM), 32'd5);
        check("mul_rw_m",      32'(RegWriteM), 32'd1);
        set_nop(); RD1D = 7; RD2D = 6; ALUControlD = 4'd11; RdD = 8; RegWriteD = 1;
        edge1();
        set_nop();
        edge1();
        check("mul2_busy", 32'(BusyE), 32'd1);
        RST_N = 1'b0;
        #1;
        check("mulrst_busy",  32'(BusyE), 32'd0);
        check("mulrst_alu_m", ALUResultM, 32'h0);
        check("mulrst_rd_m",  32'(RdM), 32'd0);
        edge1();
        RST_N = 1'b1;
        edge1();
        check("mulrst_after_busy",  32'(BusyE), 32'd0);
        check("mulrst_after_alu_m", ALUResultM, 32'h0);
`else
        set_nop(); RD1D = 32'hFFFF_FFFF; RD2D = 3; ALUControlD = 4'd11; RdD = 5; RegWriteD = 1;
        cycle();
        set_nop();
        cycle();
        check("mul_off_res",  ALUResultM, 32'h0);
        check("mul_off_busy", 32'(BusyE), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
